indexed_sum_buffer: RTL and testbench

INDEXED_SUM_BUFFER -- requirements
Module: indexed_sum_buffer

---
 rtl/indexed_sum_buffer.sv | 109 ++++++++++
 tb/tb_indexed_sum_buffer.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/indexed_sum_buffer.sv
// Indexed adder store: writes keep (a+b) and its carry per entry, reads return word/carry/bit/err.
// Latency: writes land on the accepting edge; read results appear one cycle after acceptance.
// Backpressure: in_ready drops only during clear; rd_ready follows the output register's free slot.
module indexed_sum_buffer #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4,
    localparam int IW = $clog2(DEPTH),
    localparam int BW = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [IW-1:0]    in_idx,
    input  logic             rd_valid,
    output logic             rd_ready,
    input  logic [IW-1:0]    rd_idx,
    input  logic [BW-1:0]    rd_bit,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_word,
    output logic             out_carry,
    output logic             out_bit,
    output logic             out_err
);

    typedef struct packed {
        logic [WIDTH-1:0] word;
        logic             carry;
        logic             sel_bit;
        logic             err;
    } res_t;

    logic [WIDTH-1:0] entry_mem [DEPTH];
    logic             carry_mem [DEPTH];
    logic [DEPTH-1:0] written;
    logic             ready_en;
    logic [WIDTH:0]   sum_full;
    logic             wr_fire;
    logic             rd_fire;
    res_t             rd_res;
    res_t             out_res;

    // Handshakes stay closed during reset and open on the first edge after release.
    assign in_ready = ready_en && !clear;
    assign rd_ready = ready_en && (!out_valid || out_ready);
    assign wr_fire  = in_valid && in_ready;
    assign rd_fire  = rd_valid && rd_ready;
    assign sum_full = {1'b0, in_a} + {1'b0, in_b};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_en <= 1'b0;
        end else begin
            ready_en <= 1'b1;
        end
    end

    // Clear masks the write through in_ready, so it wins over a same-cycle write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            written <= '0;
        end else if (clear) begin
            written <= '0;
        end else if (wr_fire) begin
            written[in_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_fire) begin
            entry_mem[in_idx] <= sum_full[WIDTH-1:0];
            carry_mem[in_idx] <= sum_full[WIDTH];
        end
    end

    // Read sees pre-edge storage and flags, giving read-before-write/clear ordering.
    always_comb begin
        rd_res     = '0;
        rd_res.err = 1'b1;
        if (written[rd_idx]) begin
            rd_res.word    = entry_mem[rd_idx];
            rd_res.carry   = carry_mem[rd_idx];
            rd_res.sel_bit = entry_mem[rd_idx][rd_bit];
            rd_res.err     = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_res   <= '0;
        end else if (rd_fire) begin
            out_valid <= 1'b1;
            out_res   <= rd_res;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    assign out_word  = out_res.word;
    assign out_carry = out_res.carry;
    assign out_bit   = out_res.sel_bit;
    assign out_err   = out_res.err;

endmodule

// File: tb/tb_indexed_sum_buffer.sv
// Bench for indexed_sum_buffer (WIDTH=4, DEPTH=4): directed vectors, corner sequences, random vs model.
module tb_indexed_sum_buffer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clear;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_a;
    logic [3:0] in_b;
    logic [1:0] in_idx;
    logic       rd_valid;
    logic       rd_ready;
    logic [1:0] rd_idx;
    logic [1:0] rd_bit;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_word;
    logic       out_carry;
    logic       out_bit;
    logic       out_err;

    int n_checks = 0;
    int n_fail   = 0;

    indexed_sum_buffer #(.WIDTH(4), .DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_idx(in_idx),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_idx(rd_idx), .rd_bit(rd_bit),
        .out_valid(out_valid), .out_ready(out_ready), .out_word(out_word),
        .out_carry(out_carry), .out_bit(out_bit), .out_err(out_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       wr;
        logic [1:0] widx;
        logic [3:0] a;
        logic [3:0] b;
        logic       rd;
        logic [1:0] ridx;
        logic [1:0] rbit;
        logic       exp_valid;
        logic [3:0] exp_word;
        logic       exp_carry;
        logic       exp_bit;
        logic       exp_err;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string name, input logic [3:0] w, input logic c,
                           input logic b, input logic e);
        chk({name, ".valid"}, out_valid, 1);
        chk({name, ".word"},  out_word,  w);
        chk({name, ".carry"}, out_carry, c);
        chk({name, ".bit"},   out_bit,   b);
        chk({name, ".err"},   out_err,   e);
    endtask

    task automatic idle();
        clear = 0; in_valid = 0; in_a = 0; in_b = 0; in_idx = 0;
        rd_valid = 0; rd_idx = 0; rd_bit = 0; out_ready = 1;
    endtask

    // Reference model state
    int  m_mem [4];
    bit  m_carry [4];
    bit  m_wr [4];
    bit  m_valid;
    int  m_word;
    bit  m_c;
    bit  m_b;
    bit  m_e;

    initial begin
        //            wr widx a      b      rd ridx rbit vld word   c  b  e
        vecs[0] = '{1, 1, 4'b0010, 4'b1100, 0, 0, 0, 0, 4'b0000, 0, 0, 0};
        vecs[1] = '{0, 0, 4'b0000, 4'b0000, 1, 1, 3, 1, 4'b1110, 0, 1, 0};
        vecs[2] = '{1, 2, 4'b1111, 4'b0001, 0, 0, 0, 0, 4'b0000, 0, 0, 0};
        vecs[3] = '{0, 0, 4'b0000, 4'b0000, 1, 2, 0, 1, 4'b0000, 1, 0, 0};
        vecs[4] = '{0, 0, 4'b0000, 4'b0000, 1, 3, 0, 1, 4'b0000, 0, 0, 1};
        vecs[5] = '{1, 1, 4'b0001, 4'b0001, 1, 1, 1, 1, 4'b1110, 0, 1, 0};
        vecs[6] = '{0, 0, 4'b0000, 4'b0000, 1, 1, 1, 1, 4'b0010, 0, 1, 0};
        vecs[7] = '{0, 0, 4'b0000, 4'b0000, 1, 2, 3, 1, 4'b0000, 1, 0, 0};

        // Reset state
        idle();
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.in_ready", in_ready, 0);
        chk("rst.rd_ready", rd_ready, 0);
        chk("rst.out_valid", out_valid, 0);
        chk("rst.outs", {out_word, out_carry, out_bit, out_err}, 0);
        rst_n = 1;
        #1;
        chk("rel.in_ready_before_edge", in_ready, 0);
        step();
        chk("rel.in_ready", in_ready, 1);
        chk("rel.rd_ready", rd_ready, 1);

        // Directed vectors
        for (int i = 0; i < 8; i++) begin
            in_valid = vecs[i].wr; in_idx = vecs[i].widx; in_a = vecs[i].a; in_b = vecs[i].b;
            rd_valid = vecs[i].rd; rd_idx = vecs[i].ridx; rd_bit = vecs[i].rbit;
            out_ready = 1; clear = 0;
            step();
            chk($sformatf("vec%0d.valid", i), out_valid, vecs[i].exp_valid);
            if (vecs[i].exp_valid)
                chk_out($sformatf("vec%0d", i), vecs[i].exp_word, vecs[i].exp_carry,
                        vecs[i].exp_bit, vecs[i].exp_err);
        end

        // Backpressure: result held, rd_ready low, release gives next result
        idle();
        rd_valid = 1; rd_idx = 1; rd_bit = 1;
        step();
        chk_out("bp.first", 4'b0010, 0, 1, 0);
        out_ready = 0; rd_idx = 2; rd_bit = 0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("bp.rd_ready%0d", k), rd_ready, 0);
            step();
            chk_out($sformatf("bp.hold%0d", k), 4'b0010, 0, 1, 0);
        end
        out_ready = 1;
        #1;
        chk("bp.rd_ready_release", rd_ready, 1);
        step();
        chk_out("bp.next", 4'b0000, 1, 0, 0);
        rd_valid = 0;
        step();
        chk("bp.drop", out_valid, 0);

        // Clear: read on the clear edge sees pre-clear flags; clear blocks write
        idle();
        in_valid = 1; in_idx = 0; in_a = 4'd3; in_b = 4'd4;
        step();
        clear = 1; in_valid = 1; in_idx = 3; in_a = 1; in_b = 1;
        rd_valid = 1; rd_idx = 0; rd_bit = 2;
        #1;
        chk("clr.in_ready", in_ready, 0);
        step();
        chk_out("clr.same_edge", 4'b0111, 0, 1, 0);
        idle();
        rd_valid = 1; rd_idx = 1;
        step();
        chk_out("clr.idx1", 4'b0000, 0, 0, 1);
        rd_idx = 3;
        step();
        chk_out("clr.idx3", 4'b0000, 0, 0, 1);
        rd_idx = 0;
        step();
        chk_out("clr.idx0", 4'b0000, 0, 0, 1);

        // Reset mid-output discards the pending result immediately
        out_ready = 0;
        step();
        chk("mid.pending", out_valid, 1);
        rst_n = 0;
        #1;
        chk("mid.out_valid", out_valid, 0);
        chk("mid.out_err", out_err, 0);
        chk("mid.rd_ready", rd_ready, 0);
        #2;
        rst_n = 1;
        idle();
        step();
        chk("mid.after_valid", out_valid, 0);
        chk("mid.after_in_ready", in_ready, 1);

        // Randomized phase against the model; flags are clear after the reset above
        for (int j = 0; j < 4; j++) begin
            m_mem[j] = 0; m_carry[j] = 0; m_wr[j] = 0;
        end
        m_valid = 0; m_word = 0; m_c = 0; m_b = 0; m_e = 0;
        for (int t = 0; t < 600; t++) begin
            bit acc;
            int s;
            clear     = ($urandom_range(0, 15) == 0);
            in_valid  = $urandom_range(0, 1);
            in_a      = 4'($urandom_range(0, 15));
            in_b      = 4'($urandom_range(0, 15));
            in_idx    = 2'($urandom_range(0, 3));
            rd_valid  = ($urandom_range(0, 3) != 0);
            rd_idx    = 2'($urandom_range(0, 3));
            rd_bit    = 2'($urandom_range(0, 3));
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            chk("rnd.in_ready", in_ready, !clear);
            chk("rnd.rd_ready", rd_ready, (!m_valid || out_ready));
            acc = rd_valid && (!m_valid || out_ready);
            if (acc) begin
                m_valid = 1;
                if (m_wr[rd_idx]) begin
                    m_word = m_mem[rd_idx];
                    m_c    = m_carry[rd_idx];
                    m_b    = ((m_mem[rd_idx] >> rd_bit) & 1) != 0;
                    m_e    = 0;
                end else begin
                    m_word = 0; m_c = 0; m_b = 0; m_e = 1;
                end
            end else if (out_ready) begin
                m_valid = 0;
            end
            if (clear) begin
                for (int j = 0; j < 4; j++) m_wr[j] = 0;
            end else if (in_valid) begin
                s = int'(in_a) + int'(in_b);
                m_mem[in_idx]   = s % 16;
                m_carry[in_idx] = (s >= 16);
                m_wr[in_idx]    = 1;
            end
            step();
            chk("rnd.valid", out_valid, m_valid);
            if (m_valid)
                chk("rnd.result", {out_word, out_carry, out_bit, out_err},
                    {4'(m_word), m_c, m_b, m_e});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
